// File: rtl/counter_arbiter.sv
// -----------------------------------------------------------------------------
// counter_arbiter
//   Shares one WIDTH-bit down-counter interval timer between two requesters.
//   A granted requester has its interval length loaded into the counter. The
//   counter then runs down to zero, and the requester receives a one-cycle
//   done pulse. Dropping the request while the counter runs aborts the interval.
//
//   Configuration macro: COUNTER_ARB_RR_EN
//     defined   - round-robin arbitration on a tie (the requester not served
//                 last wins). The pointer resets to 1, so requester 0 wins
//                 the first tie.
//     undefined - fixed priority: req[0] always beats req[1].
//
// Ports
//   clk    in   rising-edge system clock
//   reset  in   asynchronous active-low reset (0 = in reset)
//   req    in   [1:0]       per-requester level request
//   len0   in   [WIDTH-1:0] interval load value for requester 0 (sampled at grant)
//   len1   in   [WIDTH-1:0] interval load value for requester 1 (sampled at grant)
//   gnt    out  [1:0]       one-hot grant, held for the whole interval
//   done   out  [1:0]       one-cycle expiry pulse to the granted requester
//   busy   out              high whenever the FSM is not IDLE
//   q      out  [WIDTH-1:0] current counter value
// -----------------------------------------------------------------------------
module counter_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] len0,
    input  logic [WIDTH-1:0] len1,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic             busy,
    output logic [WIDTH-1:0] q
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nx_s;
    logic [1:0]       gnt_r;
    logic [1:0]       gnt_nx_s;
    logic [1:0]       done_r;
    logic [1:0]       done_nx_s;
    logic             busy_r;
    logic             busy_nx_s;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nx_s;
    logic             win_s;      // arbitration winner index (0 or 1)
    logic             req_gnt_s;  // request level of the currently granted requester

`ifdef COUNTER_ARB_RR_EN
    logic             last_r;     // index of the requester served last
    logic             grant_s;    // a grant is issued at this edge

    // Tie goes to the requester not served last; a lone requester always wins.
    always_comb begin
        win_s = 1'b0;
        if (req == 2'b11) begin
            win_s = ~last_r;
        end else begin
            win_s = req[1];
        end
    end

    // Last-served pointer, updated at every grant (including later aborts).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_r <= 1'b1;
        end else if (grant_s) begin
            last_r <= win_s;
        end else begin
            last_r <= last_r;
        end
    end

    assign grant_s = (state_r == IDLE) && (req != 2'b00);
`else
    // Fixed priority: requester 1 wins only when requester 0 is not asking.
    always_comb begin
        win_s = 1'b0;
        if (req[0]) begin
            win_s = 1'b0;
        end else begin
            win_s = 1'b1;
        end
    end
`endif

    // The grant is one-hot, so gnt_r[1] identifies the granted requester.
    assign req_gnt_s = gnt_r[1] ? req[1] : req[0];

    // Next-state and next-output logic for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_nx_s = state_r;
        gnt_nx_s   = gnt_r;
        done_nx_s  = 2'b00;
        q_nx_s     = q_r;
        case (state_r)
            IDLE: begin
                if (req != 2'b00) begin
                    state_nx_s = RUN;
                    gnt_nx_s   = win_s ? 2'b10 : 2'b01;
                    q_nx_s     = win_s ? len1 : len0;
                end else begin
                    state_nx_s = IDLE;
                    gnt_nx_s   = 2'b00;
                end
            end
            RUN: begin
                // Abort has priority over both decrement and expiry; q holds.
                if (!req_gnt_s) begin
                    state_nx_s = IDLE;
                    gnt_nx_s   = 2'b00;
                end else if (q_r != {WIDTH{1'b0}}) begin
                    q_nx_s = q_r - {{(WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    state_nx_s = DONE;
                    done_nx_s  = gnt_r;
                end
            end
            DONE: begin
                state_nx_s = IDLE;
                gnt_nx_s   = 2'b00;
            end
            default: begin
                state_nx_s = IDLE;
                gnt_nx_s   = 2'b00;
                q_nx_s     = {WIDTH{1'b0}};
            end
        endcase
        busy_nx_s = (state_nx_s != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            gnt_r   <= 2'b00;
            done_r  <= 2'b00;
            busy_r  <= 1'b0;
            q_r     <= {WIDTH{1'b0}};
        end else begin
            state_r <= state_nx_s;
            gnt_r   <= gnt_nx_s;
            done_r  <= done_nx_s;
            busy_r  <= busy_nx_s;
            q_r     <= q_nx_s;
        end
    end

    assign gnt  = gnt_r;
    assign done = done_r;
    assign busy = busy_r;
    assign q    = q_r;

endmodule

// File: tb/tb_counter_arbiter.sv
// -----------------------------------------------------------------------------
// tb_counter_arbiter
//   Directed bench for counter_arbiter (WIDTH = 4). Each step drives inputs
//   one time unit after a rising edge and observes outputs one time unit after
//   the next rising edge. The expected values are worked out by hand from the
//   timer behaviour. Tie-break expectations depend on COUNTER_ARB_RR_EN.
// -----------------------------------------------------------------------------
module tb_counter_arbiter;

    localparam int WIDTH = 4;

    logic             clk;
    logic             reset;
    logic [1:0]       req;
    logic [WIDTH-1:0] len0;
    logic [WIDTH-1:0] len1;
    logic [1:0]       gnt;
    logic [1:0]       done;
    logic             busy;
    logic [WIDTH-1:0] q;

    int checks = 0;
    int errors = 0;

    counter_arbiter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .len0  (len0),
        .len1  (len1),
        .gnt   (gnt),
        .done  (done),
        .busy  (busy),
        .q     (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] e_gnt, input logic [1:0] e_done,
                             input logic e_busy, input logic [WIDTH-1:0] e_q);
        check({tag, ".gnt"},  {6'd0, gnt},  {6'd0, e_gnt});
        check({tag, ".done"}, {6'd0, done}, {6'd0, e_done});
        check({tag, ".busy"}, {7'd0, busy}, {7'd0, e_busy});
        check({tag, ".q"},    {4'd0, q},    {4'd0, e_q});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] tie2_gnt;
        logic [3:0] tie2_q;
`ifdef COUNTER_ARB_RR_EN
        tie2_gnt = 2'b10;
`else
        tie2_gnt = 2'b01;
`endif
        tie2_q = 4'd1;

        reset = 1'b0;
        req   = 2'b00;
        len0  = 4'd0;
        len1  = 4'd0;
        #1;
        check_all("reset", 2'b00, 2'b00, 1'b0, 4'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        tick();
        check_all("idle", 2'b00, 2'b00, 1'b0, 4'd0);

        // Single request, len0 = 3: q 3,2,1,0 then done for one cycle.
        req  = 2'b01;
        len0 = 4'd3;
        tick(); check_all("single.grant", 2'b01, 2'b00, 1'b1, 4'd3);
        len0 = 4'd9;  // must be ignored while running
        tick(); check_all("single.q2", 2'b01, 2'b00, 1'b1, 4'd2);
        tick(); check_all("single.q1", 2'b01, 2'b00, 1'b1, 4'd1);
        tick(); check_all("single.q0", 2'b01, 2'b00, 1'b1, 4'd0);
        tick(); check_all("single.done", 2'b01, 2'b01, 1'b1, 4'd0);
        req = 2'b00;
        tick(); check_all("single.idle", 2'b00, 2'b00, 1'b0, 4'd0);
        tick(); check_all("single.stay", 2'b00, 2'b00, 1'b0, 4'd0);

        // Zero length on requester 1: one RUN cycle with q = 0, then done.
        req  = 2'b10;
        len1 = 4'd0;
        len0 = 4'd7;
        tick(); check_all("zero.grant", 2'b10, 2'b00, 1'b1, 4'd0);
        tick(); check_all("zero.done", 2'b10, 2'b10, 1'b1, 4'd0);
        req = 2'b00;
        tick(); check_all("zero.idle", 2'b00, 2'b00, 1'b0, 4'd0);

        // Tie held high, len = 1 each: grants separated by one IDLE cycle.
        req  = 2'b11;
        len0 = 4'd1;
        len1 = 4'd1;
        tick(); check_all("tie.g1", 2'b01, 2'b00, 1'b1, 4'd1);
        tick(); check_all("tie.g1q0", 2'b01, 2'b00, 1'b1, 4'd0);
        tick(); check_all("tie.g1done", 2'b01, 2'b01, 1'b1, 4'd0);
        tick(); check_all("tie.idle1", 2'b00, 2'b00, 1'b0, 4'd0);
        tick(); check_all("tie.g2", tie2_gnt, 2'b00, 1'b1, tie2_q);
        tick(); check_all("tie.g2q0", tie2_gnt, 2'b00, 1'b1, 4'd0);
        tick(); check_all("tie.g2done", tie2_gnt, tie2_gnt, 1'b1, 4'd0);
        tick(); check_all("tie.idle2", 2'b00, 2'b00, 1'b0, 4'd0);
        tick(); check_all("tie.g3", 2'b01, 2'b00, 1'b1, 4'd1);
        req = 2'b00;
        tick(); check_all("tie.abort", 2'b00, 2'b00, 1'b0, 4'd1);

        // Abort: len0 = 5, drop req[0] once q = 3; q holds, no done.
        req  = 2'b01;
        len0 = 4'd5;
        tick(); check_all("abort.grant", 2'b01, 2'b00, 1'b1, 4'd5);
        tick(); check_all("abort.q4", 2'b01, 2'b00, 1'b1, 4'd4);
        tick(); check_all("abort.q3", 2'b01, 2'b00, 1'b1, 4'd3);
        req = 2'b00;
        tick(); check_all("abort.idle", 2'b00, 2'b00, 1'b0, 4'd3);
        tick(); check_all("abort.hold", 2'b00, 2'b00, 1'b0, 4'd3);

        // Async reset mid-run at q = 2, then a tie must go to requester 0.
        req  = 2'b01;
        len0 = 4'd5;
        tick(); check_all("areset.grant", 2'b01, 2'b00, 1'b1, 4'd5);
        tick();
        tick();
        tick(); check_all("areset.q2", 2'b01, 2'b00, 1'b1, 4'd2);
        #2;
        reset = 1'b0;
        #1;
        check_all("areset.cleared", 2'b00, 2'b00, 1'b0, 4'd0);
        req  = 2'b11;
        len0 = 4'd2;
        len1 = 4'd4;
        @(negedge clk);
        reset = 1'b1;
        tick(); check_all("areset.tie", 2'b01, 2'b00, 1'b1, 4'd2);
        req = 2'b00;
        tick(); check_all("areset.abort", 2'b00, 2'b00, 1'b0, 4'd2);

        // Saturation: len0 = 15 counts to 0 without wrap; done 16 cycles later.
        req  = 2'b01;
        len0 = 4'd15;
        tick(); check_all("sat.grant", 2'b01, 2'b00, 1'b1, 4'd15);
        for (int k = 1; k <= 15; k++) begin
            tick();
            check_all("sat.run", 2'b01, 2'b00, 1'b1, 4'(15 - k));
        end
        tick(); check_all("sat.done", 2'b01, 2'b01, 1'b1, 4'd0);
        req = 2'b00;
        tick(); check_all("sat.idle", 2'b00, 2'b00, 1'b0, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
